// File: rtl/dot_product_seq.sv
// Sequencer that computes bias + sum(w[i]*x[i]) by driving external FP multiplier and adder
// helpers over level start/done handshakes, one element at a time in index order.
module dot_product_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int VEC_LEN    = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] bias,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] w_rdata,
    input  logic [DATA_WIDTH-1:0] x_rdata,
    output logic                  mul_start,
    input  logic                  mul_done,
    output logic [DATA_WIDTH-1:0] mul_w,
    output logic [DATA_WIDTH-1:0] mul_x,
    input  logic [DATA_WIDTH-1:0] mul_result,
    output logic                  add_start,
    input  logic                  add_done,
    output logic [DATA_WIDTH-1:0] add_a,
    output logic [DATA_WIDTH-1:0] add_b,
    input  logic [DATA_WIDTH-1:0] add_result
);

    typedef enum logic [3:0] {
        IDLE, FETCH, LATCH, MUL_REQ, MUL_REL, ADD_REQ, ADD_REL, NEXT, FINISH
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(VEC_LEN - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] product;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            product   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            mem_addr  <= '0;
            mul_start <= 1'b0;
            mul_w     <= '0;
            mul_x     <= '0;
            add_start <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= bias;
                        idx      <= '0;
                        mem_addr <= '0;
                        busy     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: state <= LATCH;
                LATCH: begin
                    mul_w     <= w_rdata;
                    mul_x     <= x_rdata;
                    mul_start <= 1'b1;
                    state     <= MUL_REQ;
                end
                MUL_REQ: begin
                    if (mul_done) begin
                        product   <= mul_result;
                        mul_start <= 1'b0;
                        state     <= MUL_REL;
                    end
                end
                // Helper must release done before the next request is raised.
                MUL_REL: begin
                    if (!mul_done) begin
                        add_a     <= acc;
                        add_b     <= product;
                        add_start <= 1'b1;
                        state     <= ADD_REQ;
                    end
                end
                ADD_REQ: begin
                    if (add_done) begin
                        acc       <= add_result;
                        add_start <= 1'b0;
                        state     <= ADD_REL;
                    end
                end
                ADD_REL: begin
                    if (!add_done) state <= NEXT;
                end
                NEXT: begin
                    if (idx == LAST_IDX) begin
                        state <= FINISH;
                    end else begin
                        idx      <= idx + 1'b1;
                        mem_addr <= idx + 1'b1;
                        state    <= FETCH;
                    end
                end
                FINISH: begin
                    result <= acc;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dot_product_seq.md
Name: dot_product_seq

Overview:
- Sequencer directly upstream of the FP32 `multiplier` stage in the GRU gate datapath.
- Walks one weight row and the input vector from read-only memories and drives the multiplier through its start/done four-phase handshake.
- Accumulates each product onto a bias through an FP adder wrapper that uses the same start/done protocol.
- Delivers one pre-activation dot product per request to the gate activation logic.

Parameters:
- DATA_WIDTH, 32, IEEE-754 word width.
- VEC_LEN, 8, number of elements per dot product; must be >= 1.
- ADDR_WIDTH, 3, memory address width; must be >= clog2(VEC_LEN), and at least 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- bias  input  DATA_WIDTH  accumulator initial value; captured when start is accepted.
- busy  output  1  high from the cycle after acceptance through the FINISH cycle.
- done  output  1  single-cycle pulse; result is valid in the same cycle.
- result  output  DATA_WIDTH  final accumulator value; held until the next FINISH.
- mem_addr  output  ADDR_WIDTH  shared read address for the weight and input memories.
- w_rdata  input  DATA_WIDTH  weight memory data; valid 1 cycle after mem_addr.
- x_rdata  input  DATA_WIDTH  input memory data; valid 1 cycle after mem_addr.
- mul_start  output  1  multiplier request (level).
- mul_done  input  1  multiplier completion (level).
- mul_w  output  DATA_WIDTH  multiplier operand A; registered.
- mul_x  output  DATA_WIDTH  multiplier operand B; registered.
- mul_result  input  DATA_WIDTH  product.
- add_start  output  1  adder request (level).
- add_done  input  1  adder completion (level).
- add_a  output  DATA_WIDTH  accumulator operand.
- add_b  output  DATA_WIDTH  product operand.
- add_result  input  DATA_WIDTH  sum.

Behaviour:
- Reset values: all registered outputs are 0 (busy, done, result, mem_addr, mul_start, add_start, mul_w, mul_x, add_a, add_b); internal index and accumulator are 0; state is IDLE.
- rst has priority over every other input. Reset mid-operation returns to IDLE within one edge and drops mul_start/add_start. The partial accumulation is discarded and result keeps its reset value (0).
- States: IDLE, FETCH, LATCH, MUL_REQ, MUL_REL, ADD_REQ, ADD_REL, NEXT, FINISH.
- IDLE, start=1: acc<=bias, idx<=0, mem_addr<=0, busy<=1, go to FETCH. start is ignored in every other state.
- FETCH: one wait cycle for memory read latency. Go to LATCH.
- LATCH: mul_w<=w_rdata, mul_x<=x_rdata, mul_start<=1. Go to MUL_REQ.
- MUL_REQ: hold mul_start=1 until mul_done=1. On mul_done: capture product<=mul_result, mul_start<=0, go to MUL_REL.
- MUL_REL: wait until mul_done=0. The multiplier clears done one cycle after start drops, so the next request must not issue before this. Then add_a<=acc, add_b<=product, add_start<=1, go to ADD_REQ.
- ADD_REQ: on add_done=1, acc<=add_result, add_start<=0, go to ADD_REL.
- ADD_REL: wait until add_done=0, then go to NEXT.
- NEXT, idx==VEC_LEN-1: go to FINISH.
- NEXT, otherwise: idx<=idx+1, mem_addr<=idx+1, go to FETCH.
- FINISH: result<=acc, done<=1 for exactly one cycle, busy<=0 on the following edge, return to IDLE. A start that is high in the cycle after FINISH is accepted as a new request.
- Accumulation order is fixed: ((bias + p0) + p1) + ..., in index order.
- No arithmetic is done locally; FP exceptions propagate through the values unchanged.
- Never assert mul_start and add_start in the same cycle.
- Latency with fixed-latency helpers (multiplier Lm cycles start-to-done, adder La cycles): per element 1 + 1 + Lm + 1 + La + 1 + 1 + 1 cycles, plus 1 FINISH cycle.
- The design must also tolerate arbitrary helper latency, including done arriving in the same cycle as the request, and done held high indefinitely.

Test Plan:
- VEC_LEN=4, w=1.0 (0x3F800000) for every element, x=1.0,2.0,3.0,4.0, bias=0.5 (0x3F000000), real multiplier plus FP adder -> single done pulse, result=0x41280000 (10.5), busy low afterwards.
- Bias 0, all x=0 -> result=0x00000000. Also w=-1.0, x=2.0, bias 0 -> each product 0xC0000000, result=0xC1000000 (-8.0).
- Stub helpers that hold done high for 5 cycles after start drops -> sequencer waits in MUL_REL/ADD_REL. Check a monitor: no new start while done=1, mul_start and add_start never both 1, and each start rises exactly VEC_LEN times.
- Assert rst in ADD_REQ of element 2, then restart with bias=0.5 -> mul_start/add_start go 0 on the next edge; second run gives 0x41280000 with no stale contribution.
- Pulse start while busy -> ignored, exactly one done. Hold start continuously -> back-to-back runs, each with done, and mem_addr restarting from 0.
- VEC_LEN=1, ADDR_WIDTH=1 -> one multiply and one add, result = bias + w0*x0, mem_addr stays 0.
